// File: rtl/aes128_key_schedule_seq.sv
// AES-128 key schedule: accepts a cipher key over valid/ready, expands it one
// 32-bit word per cycle through a shared RotWord/SubWord/Rcon path, and keeps
// all 11 round keys in a buffer read back by round index with one-cycle latency.
// Optional build macro KEYSCHED_ZEROIZE_EN adds a zeroize input that, like reset,
// wipes the key buffer and the read register.

// One S-box byte substitution: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox_lookup (
    input  logic [7:0] data,
    output logic [7:0] sub
);

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;

    // Multiplicative inverse as the product of the squares x^2..x^128 (zero maps to zero)
    always_comb begin
        x2   = gmul(data, data);
        x4   = gmul(x2, x2);
        x8   = gmul(x4, x4);
        x16  = gmul(x8, x8);
        x32  = gmul(x16, x16);
        x64  = gmul(x32, x32);
        x128 = gmul(x64, x64);
        inv  = gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
        sub  = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

module aes128_key_schedule_seq #(
    parameter int NROUNDS = 10,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef KEYSCHED_ZEROIZE_EN
    input  logic               zeroize,
`endif
    input  logic [127:0]       key_in,
    input  logic               key_valid,
    output logic               key_ready,
    output logic               busy,
    output logic               keys_valid,
    input  logic [IDX_W-1:0]   rk_rd_idx,
    output logic [127:0]       rk_rd_data
);

    localparam int NWORDS = 4 * (NROUNDS + 1);
    localparam logic [5:0] LAST_WORD = 6'(NWORDS - 1);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t state, state_nxt;
    logic [5:0] cnt;
    logic [7:0] rcon;
    logic [NWORDS-1:0][31:0] wbuf;
    logic [31:0] w_prev, w_old, w_new, rot, sub;
    logic [5:0] rd_base;
    logic idx_ok, zap, accept, expand_we;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

`ifdef KEYSCHED_ZEROIZE_EN
    assign zap = zeroize;
`else
    assign zap = 1'b0;
`endif

    assign key_ready = (state == IDLE) || (state == DONE);
    assign accept    = rst_n && !zap && key_valid && key_ready;
    assign expand_we = rst_n && !zap && (state == EXPAND);

    assign rot = {w_prev[23:0], w_prev[31:24]};

    genvar b;
    generate
        for (b = 0; b < 4; b++) begin : g_sbox
            aes_sbox_lookup u_sbox (.data(rot[8*b +: 8]), .sub(sub[8*b +: 8]));
        end
    endgenerate

    // State register; zeroize and reset both abort to IDLE
    always_ff @(posedge clk) begin
        if (!rst_n || zap) state <= IDLE;
        else               state <= state_nxt;
    end

    // Next-state decode and status outputs derived from the current state
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        keys_valid = 1'b0;
        case (state)
            IDLE:    if (accept) state_nxt = EXPAND;
            EXPAND: begin
                busy = 1'b1;
                if (cnt == LAST_WORD) state_nxt = DONE;
            end
            DONE: begin
                keys_valid = 1'b1;
                if (accept) state_nxt = EXPAND;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word counter and round constant advance together with each written word
    always_ff @(posedge clk) begin
        if (!rst_n || zap) begin
            cnt  <= 6'd0;
            rcon <= 8'h01;
        end else if (accept) begin
            cnt  <= 6'd4;
            rcon <= 8'h01;
        end else if (state == EXPAND) begin
            cnt <= cnt + 6'd1;
            if (cnt[1:0] == 2'b00) rcon <= xtime(rcon);
        end
    end

    // Next expanded word from w[i-4] and w[i-1]; every fourth word takes the S-box path
    always_comb begin
        w_prev = wbuf[cnt - 6'd1];
        w_old  = wbuf[cnt - 6'd4];
        if (cnt[1:0] == 2'b00) w_new = w_old ^ sub ^ {rcon, 24'h0};
        else                   w_new = w_old ^ w_prev;
    end

    // Key buffer: loaded with the cipher key on accept, then one word per expansion cycle
    always_ff @(posedge clk) begin
`ifdef KEYSCHED_ZEROIZE_EN
        if (!rst_n || zeroize) begin
            wbuf <= '0;
        end else
`endif
        if (accept) begin
            wbuf[0] <= key_in[127:96];
            wbuf[1] <= key_in[95:64];
            wbuf[2] <= key_in[63:32];
            wbuf[3] <= key_in[31:0];
        end else if (expand_we) begin
            wbuf[cnt] <= w_new;
        end
    end

    assign rd_base = 6'(rk_rd_idx) << 2;
    assign idx_ok  = 32'(rk_rd_idx) <= 32'(NROUNDS);

    // Registered round-key read; out-of-range indices return zero
    always_ff @(posedge clk) begin
        if (!rst_n || zap)  rk_rd_data <= '0;
        else if (idx_ok)    rk_rd_data <= {wbuf[rd_base], wbuf[rd_base + 6'd1],
                                           wbuf[rd_base + 6'd2], wbuf[rd_base + 6'd3]};
        else                rk_rd_data <= '0;
    end

endmodule

// File: tb/tb_aes128_key_schedule_seq.sv
// Directed testbench for aes128_key_schedule_seq using FIPS-197 and all-zero key vectors.
module tb_aes128_key_schedule_seq;

    logic         clk;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;
`ifdef KEYSCHED_ZEROIZE_EN
    logic         zeroize;
`endif

    int total = 0;
    int bad   = 0;
    int n;
    logic [127:0] rd;

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    localparam logic [127:0] A1_RK [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    localparam logic [127:0] Z_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_RK2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    localparam logic [127:0] Z_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes128_key_schedule_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef KEYSCHED_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rk_rd_idx  (rk_rd_idx),
        .rk_rd_data (rk_rd_data)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] key);
        key_in    = key;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic readKey(input int idx, output logic [127:0] data);
        rk_rd_idx = 4'(idx);
        tick();
        data = rk_rd_data;
    endtask

    task automatic waitKeysValid(input bit pulse, output int cycles);
        cycles = 0;
        while (keys_valid !== 1'b1 && cycles < 60) begin
            if (pulse) begin
                key_in    = KEY_A1;
                key_valid = (cycles < 30) && (cycles % 2 == 1);
            end
            tick();
            cycles++;
        end
        key_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        key_in    = '0;
        key_valid = 1'b0;
        rk_rd_idx = '0;
`ifdef KEYSCHED_ZEROIZE_EN
        zeroize   = 1'b0;
`endif
        tick();
        tick();
        checkOutput("rst_ready", 128'(key_ready), 128'd1);
        checkOutput("rst_busy", 128'(busy), 128'd0);
        checkOutput("rst_kvalid", 128'(keys_valid), 128'd0);
        checkOutput("rst_rdata", rk_rd_data, 128'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] A.1 key expansion");
        applyStimulus(KEY_A1);
        checkOutput("a1_busy", 128'(busy), 128'd1);
        checkOutput("a1_ready", 128'(key_ready), 128'd0);
        checkOutput("a1_kvalid_low", 128'(keys_valid), 128'd0);
        waitKeysValid(1'b0, n);
        checkOutput("a1_latency", 128'(n), 128'd40);
        checkOutput("a1_busy_done", 128'(busy), 128'd0);
        checkOutput("a1_ready_done", 128'(key_ready), 128'd1);

        $display("[TB] read sweep and out-of-range indices");
        for (int i = 0; i <= 10; i++) begin
            readKey(i, rd);
            checkOutput($sformatf("a1_rk%0d", i), rd, A1_RK[i]);
        end
        rk_rd_idx = 4'd11;
        #1;
        checkOutput("latency_hold", rk_rd_data, A1_RK[10]);
        for (int i = 11; i <= 15; i++) begin
            readKey(i, rd);
            checkOutput($sformatf("oor_idx%0d", i), rd, 128'd0);
        end

        $display("[TB] back-to-back zero key from DONE");
        key_in    = '0;
        key_valid = 1'b1;
        checkOutput("b2b_kvalid_before", 128'(keys_valid), 128'd1);
        tick();
        key_valid = 1'b0;
        checkOutput("b2b_kvalid_drop", 128'(keys_valid), 128'd0);
        checkOutput("b2b_busy", 128'(busy), 128'd1);
        waitKeysValid(1'b1, n);
        checkOutput("zero_latency", 128'(n), 128'd40);
        readKey(1, rd);
        checkOutput("zero_rk1", rd, Z_RK1);
        readKey(2, rd);
        checkOutput("zero_rk2", rd, Z_RK2);
        readKey(10, rd);
        checkOutput("zero_rk10", rd, Z_RK10);

`ifndef KEYSCHED_ZEROIZE_EN
        $display("[TB] reset keeps buffer contents");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("persist_rdata_rst", rk_rd_data, 128'd0);
        checkOutput("persist_kvalid", 128'(keys_valid), 128'd0);
        readKey(10, rd);
        checkOutput("persist_rk10", rd, Z_RK10);
`endif

        $display("[TB] reset in mid-expansion");
        applyStimulus(KEY_A1);
        for (int i = 0; i < 19; i++) tick();
        checkOutput("mid_busy_before", 128'(busy), 128'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("mid_busy", 128'(busy), 128'd0);
        checkOutput("mid_kvalid", 128'(keys_valid), 128'd0);
        checkOutput("mid_ready", 128'(key_ready), 128'd1);
        tick();
        checkOutput("mid_idle_stays", 128'(busy), 128'd0);
        applyStimulus(KEY_A1);
        waitKeysValid(1'b0, n);
        checkOutput("mid_latency", 128'(n), 128'd40);
        readKey(10, rd);
        checkOutput("mid_rk10", rd, A1_RK[10]);
        readKey(5, rd);
        checkOutput("mid_rk5", rd, A1_RK[5]);

`ifdef KEYSCHED_ZEROIZE_EN
        $display("[TB] zeroize in DONE");
        rk_rd_idx = 4'd10;
        zeroize   = 1'b1;
        key_in    = '0;
        key_valid = 1'b1;
        tick();
        zeroize   = 1'b0;
        key_valid = 1'b0;
        checkOutput("zz_kvalid", 128'(keys_valid), 128'd0);
        checkOutput("zz_busy", 128'(busy), 128'd0);
        checkOutput("zz_ready", 128'(key_ready), 128'd1);
        checkOutput("zz_rdata", rk_rd_data, 128'd0);
        tick();
        checkOutput("zz_not_accepted", 128'(busy), 128'd0);
        for (int i = 0; i <= 10; i++) begin
            readKey(i, rd);
            checkOutput($sformatf("zz_rk%0d", i), rd, 128'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
